alu_cmd_master: RTL

//   Host-side initiator for the UART ALU command protocol. Accepts one operation
//   (A, B, opcode) per valid/ready request, sends it over the UART TX as three bytes
//   (A, B, {2'b00,opcode}), waits for the single result byte on the UART RX, and

---
 rtl/alu_cmd_master.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_master.sv
// Host-side initiator for the UART ALU command protocol: ships A, B and the opcode
// as three UART bytes, then waits (with timeout) for the single result byte.
module alu_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [5:0] i_opcode,
  output logic       o_tx_start,
  output logic [7:0] o_tx,
  input  logic       i_tx_done,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx,
  output logic [7:0] o_result,
  output logic       o_result_valid,
  output logic       o_timeout,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    TX_BUSY = 2'd2,
    RX_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r, state_s;
  logic [7:0]       a_r, a_s, b_r, b_s;
  logic [5:0]       op_r, op_s;
  logic [1:0]       idx_r, idx_s;
  logic             acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       tx_r, tx_s, result_r, result_s;
  logic             tx_start_r, tx_start_s, result_valid_r, result_valid_s;
  logic             timeout_r, timeout_s, ready_r, ready_s, busy_r, busy_s;

  function automatic logic [7:0] select_byte(input logic [1:0] idx, input logic [7:0] a,
                                             input logic [7:0] b, input logic [5:0] op);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = a;
      2'd1:    sel = b;
      2'd2:    sel = {2'b00, op};
      default: sel = 8'h00;
    endcase
    return sel;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_s        = state_r;
    a_s            = a_r;
    b_s            = b_r;
    op_s           = op_r;
    idx_s          = idx_r;
    acc_s          = acc_r;
    cnt_s          = cnt_r;
    tx_s           = tx_r;
    tx_start_s     = 1'b0;
    result_s       = result_r;
    result_valid_s = 1'b0;
    timeout_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_req_valid) begin
          a_s     = i_a;
          b_s     = i_b;
          op_s    = i_opcode;
          idx_s   = 2'd0;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (i_tx_done) begin
          tx_s       = select_byte(idx_r, a_r, b_r, op_r);
          tx_start_s = 1'b1;
          acc_s      = 1'b0;
          state_s    = TX_BUSY;
        end else begin
          state_s = SEND;
        end
      end
      TX_BUSY: begin
        // acc_r marks that the TX has dropped done, i.e. taken our byte
        if (!acc_r) begin
          acc_s = ~i_tx_done;
        end else if (i_tx_done) begin
          if (idx_r == 2'd2) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = RX_WAIT;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = SEND;
          end
        end else begin
          state_s = TX_BUSY;
        end
      end
      RX_WAIT: begin
        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (i_rx_done) begin
          result_s       = i_rx;
          result_valid_s = 1'b1;
          state_s        = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s = RX_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
    ready_s = (state_s == IDLE);
    busy_s  = (state_s != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      a_r            <= 8'h00;
      b_r            <= 8'h00;
      op_r           <= 6'h00;
      idx_r          <= 2'd0;
      acc_r          <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      tx_r           <= 8'h00;
      tx_start_r     <= 1'b0;
      result_r       <= 8'h00;
      result_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
      ready_r        <= 1'b1;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      a_r            <= a_s;
      b_r            <= b_s;
      op_r           <= op_s;
      idx_r          <= idx_s;
      acc_r          <= acc_s;
      cnt_r          <= cnt_s;
      tx_r           <= tx_s;
      tx_start_r     <= tx_start_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      timeout_r      <= timeout_s;
      ready_r        <= ready_s;
      busy_r         <= busy_s;
    end
  end

  assign o_req_ready    = ready_r;
  assign o_tx_start     = tx_start_r;
  assign o_tx           = tx_r;
  assign o_result       = result_r;
  assign o_result_valid = result_valid_r;
  assign o_timeout      = timeout_r;
  assign o_busy         = busy_r;

endmodule
